hdc_seq_ctrl: RTL and testbench
===============================

HDC_SEQ_CTRL -- requirements
Module: hdc_seq_ctrl

Interface
REQ-001 Parameter MAXLEN, 20, maximum symbols per sample (positions 0..MAXLEN-1).
REQ-002 Parameter ACK_TIMEOUT, 64, cycles to wait for dp_ack before abort.
REQ-003 Port clk  in  1  single clock, all logic on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port sym_valid  in  1  upstream symbol valid.
REQ-006 Port sym_ready  out  1  controller accepts symbol this cycle.
REQ-007 Port sym_data  in  5  symbol code, legal 0..9.
REQ-008 Port sym_last  in  1  symbol is last of sample.
REQ-009 Port sym_label  in  5  class label of sample, sampled with first accepted symbol.
REQ-010 Port mode  in  1  0 train, 1 classify, sampled with first accepted symbol.
REQ-011 Port dp_letter / dp_position / dp_label  out  5 each  operands to associative-memory datapath.
REQ-012 Port dp_t_signal  out  1  one-cycle symbol-issue strobe.
REQ-013 Port dp_f_signal  out  1  one-cycle sample-finalize strobe; dp_mode  out 1 valid with it.
REQ-014 Port dp_ack  in  1  one-cycle datapath completion pulse for last strobe.
REQ-015 Port sample_done  out  1  one-cycle pulse per finalized sample.
REQ-016 Port sample_count  out  16  finalized samples, wraps 0xFFFF->0.
REQ-017 Port bad_sym_count  out  16  dropped illegal symbols, saturates at 0xFFFF.
REQ-018 Port err_overflow, err_timeout  out  1 each  sticky errors; err_clr  in  1  clears both.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_ACK, FINAL, WAIT_FIN, DONE, DRAIN.
REQ-020 sym_ready SHALL be 1 only in IDLE and DRAIN (combinational from state).
REQ-021 IDLE, handshake with sym_data<=9: latch letter, position=pos_cnt, label, last; -> ISSUE.
REQ-022 IDLE, handshake with sym_data>9: drop, bad_sym_count+1; if sym_last and pos_cnt>0 -> FINAL, if sym_last and pos_cnt==0 -> IDLE, no sample_done.
REQ-023 ISSUE: dp_t_signal=1 exactly one cycle; -> WAIT_ACK.
REQ-024 WAIT_ACK on dp_ack: pos_cnt+1; last -> FINAL; else pos_cnt+1==MAXLEN -> set err_overflow, -> FINAL then DRAIN; else -> IDLE.
REQ-025 FINAL: dp_f_signal=1 one cycle, dp_mode=latched mode; -> WAIT_FIN.
REQ-026 WAIT_FIN on dp_ack -> DONE; DONE: sample_done=1 one cycle, sample_count+1, pos_cnt=0; -> DRAIN if overflow-truncated, else IDLE.
REQ-027 DRAIN: accept and discard symbols (no counting) until handshake with sym_last, then -> IDLE.
REQ-028 Timeout counter SHALL reset on entry to WAIT_ACK/WAIT_FIN; reaching ACK_TIMEOUT sets err_timeout, pos_cnt=0, -> IDLE, no sample_done.
REQ-029 dp_ack outside WAIT_ACK/WAIT_FIN SHALL be ignored.
REQ-030 dp_letter/dp_position/dp_label SHALL hold stable from ISSUE through WAIT_ACK exit.
REQ-031 err_clr simultaneous with new error SHALL leave the error set.
REQ-032 Minimum per-symbol throughput: 3 cycles with dp_ack returned the cycle after dp_t_signal.

Reset
REQ-033 rst low SHALL immediately force IDLE, pos_cnt=0, all strobes 0, counters 0, errors 0, dp_* 0.
REQ-034 Reset mid-sample SHALL discard the partial sample with no dp_f_signal issued.
REQ-035 First state advance SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-036 State enum, symbol width (5), MAXLEN default and ACK_TIMEOUT default SHALL live in shared package hdc_pkg.
REQ-037 One sub-module, hdc_ack_watchdog (load/count/expire), SHALL implement REQ-028.

Verification
REQ-038 Sample "3 1 4" label 2 mode 0, dp_ack 1 cycle after strobes -> three dp_t_signal with positions 0,1,2, one dp_f_signal dp_mode=0, sample_done, sample_count=1.
REQ-039 Sample "7 A 5" (A=10) -> bad_sym_count=1, positions 0,1 issued for 7,5, one finalize.
REQ-040 MAXLEN+3 symbols last on final -> MAXLEN issues, err_overflow=1, one sample_done, 3 symbols drained, next sample starts at position 0.
REQ-041 dp_ack withheld after first dp_t_signal -> err_timeout=1 after 64 cycles, IDLE, sample_count unchanged; err_clr -> 0.
REQ-042 rst low during WAIT_ACK of symbol 2 -> all outputs 0 immediately, no dp_f_signal; next sample begins at position 0.
REQ-043 Single illegal symbol with sym_last -> no dp_f_signal, no sample_done, bad_sym_count=1.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared state type, symbol width and defaults for the HDC sequencer
package hdc_pkg;
  localparam int SYM_W = 5;
  localparam int MAXLEN_DEF = 20;
  localparam int ACK_TIMEOUT_DEF = 64;
  localparam logic [SYM_W-1:0] SYM_MAX = 5'd9;
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_FINAL, S_WAIT_FIN, S_DONE, S_DRAIN
  } state_e;
  function automatic logic sym_legal(input logic [SYM_W-1:0] s);
    return s <= SYM_MAX;
  endfunction
endpackage

// File: rtl/hdc_ack_watchdog.sv
// hdc_ack_watchdog: counts cycles spent waiting for dp_ack and flags expiry
module hdc_ack_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire_o = count_i && (cnt_q == CW'(TIMEOUT - 1));
  // restart on entry to a wait state, then count until expiry
  always_comb cnt_d = load_i ? '0 : (count_i && !expire_o) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hdc_seq_ctrl.sv
// hdc_seq_ctrl: sequences symbols of a sample into the associative-memory datapath
module hdc_seq_ctrl
  import hdc_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [SYM_W-1:0] sym_data,
  input  logic             sym_last,
  input  logic [SYM_W-1:0] sym_label,
  input  logic             mode,
  output logic [SYM_W-1:0] dp_letter,
  output logic [SYM_W-1:0] dp_position,
  output logic [SYM_W-1:0] dp_label,
  output logic             dp_t_signal,
  output logic             dp_f_signal,
  output logic             dp_mode,
  input  logic             dp_ack,
  output logic             sample_done,
  output logic [15:0]      sample_count,
  output logic [15:0]      bad_sym_count,
  output logic             err_overflow,
  output logic             err_timeout,
  input  logic             err_clr
);
  state_e state_q, state_d;
  logic [SYM_W-1:0] pos_q, pos_d, letter_q, letter_d, position_q, position_d, label_q, label_d;
  logic last_q, last_d, mode_q, mode_d, trunc_q, trunc_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [15:0] scnt_q, scnt_d, bcnt_q, bcnt_d;
  logic hs, set_ovf, set_tmo, wd_load, wd_count, wd_expire;

  assign sym_ready = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign hs = sym_valid && sym_ready;
  assign wd_load = (state_q == S_ISSUE) || (state_q == S_FINAL);
  assign wd_count = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_FIN);
  assign dp_t_signal = state_q == S_ISSUE;
  assign dp_f_signal = state_q == S_FINAL;
  assign sample_done = state_q == S_DONE;
  assign dp_letter = letter_q;
  assign dp_position = position_q;
  assign dp_label = label_q;
  assign dp_mode = mode_q;
  assign sample_count = scnt_q;
  assign bad_sym_count = bcnt_q;
  assign err_overflow = ovf_q;
  assign err_timeout = tmo_q;

  hdc_ack_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .load_i(wd_load), .count_i(wd_count), .expire_o(wd_expire)
  );

  // next-state, operand latching, counters and sticky errors
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    letter_d = letter_q;
    position_d = position_q;
    label_d = label_q;
    last_d = last_q;
    mode_d = mode_q;
    trunc_d = trunc_q;
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    set_ovf = 1'b0;
    set_tmo = 1'b0;
    case (state_q)
      S_IDLE:
        if (hs && sym_legal(sym_data)) begin
          letter_d = sym_data;
          position_d = pos_q;
          last_d = sym_last;
          label_d = (pos_q == '0) ? sym_label : label_q;
          mode_d = (pos_q == '0) ? mode : mode_q;
          state_d = S_ISSUE;
        end else if (hs) begin
          bcnt_d = &bcnt_q ? bcnt_q : bcnt_q + 16'd1;
          state_d = (sym_last && pos_q != '0) ? S_FINAL : S_IDLE;
        end
      S_ISSUE: state_d = S_WAIT_ACK;
      S_WAIT_ACK:
        if (dp_ack) begin
          pos_d = pos_q + 1'b1;
          set_ovf = !last_q && (pos_q == SYM_W'(MAXLEN - 1));
          trunc_d = set_ovf;
          state_d = (last_q || set_ovf) ? S_FINAL : S_IDLE;
        end else if (wd_expire) begin
          set_tmo = 1'b1;
          pos_d = '0;
          state_d = S_IDLE;
        end
      S_FINAL: state_d = S_WAIT_FIN;
      S_WAIT_FIN:
        if (dp_ack) state_d = S_DONE;
        else if (wd_expire) begin
          set_tmo = 1'b1;
          pos_d = '0;
          trunc_d = 1'b0;
          state_d = S_IDLE;
        end
      S_DONE: begin
        scnt_d = scnt_q + 16'd1;
        pos_d = '0;
        trunc_d = 1'b0;
        state_d = trunc_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: state_d = (hs && sym_last) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    ovf_d = set_ovf || (ovf_q && !err_clr);
    tmo_d = set_tmo || (tmo_q && !err_clr);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      pos_q <= '0;
      letter_q <= '0;
      position_q <= '0;
      label_q <= '0;
      last_q <= 1'b0;
      mode_q <= 1'b0;
      trunc_q <= 1'b0;
      scnt_q <= '0;
      bcnt_q <= '0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      letter_q <= letter_d;
      position_q <= position_d;
      label_q <= label_d;
      last_q <= last_d;
      mode_q <= mode_d;
      trunc_q <= trunc_d;
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
    end
endmodule

// File: tb/tb_hdc_seq_ctrl.sv
// tb_hdc_seq_ctrl: vector table, directed corner sequences and randomized samples vs a sample-level model
module tb_hdc_seq_ctrl;
  localparam int ML = 20;
  typedef struct packed {logic [4:0] l; logic [4:0] p; logic [4:0] b;} iss_t;
  typedef struct {
    int n; logic [2:0][4:0] syms; logic [4:0] lab; logic md;
    int en; logic [2:0][4:0] elet; int efin; int ebad;
  } vec_t;

  logic clk = 0, rst = 1, sym_valid = 0, sym_last = 0, mode = 0, dp_ack = 0, err_clr = 0;
  logic [4:0] sym_data = 0, sym_label = 0;
  logic sym_ready, dp_t_signal, dp_f_signal, dp_mode, sample_done, err_overflow, err_timeout;
  logic [4:0] dp_letter, dp_position, dp_label;
  logic [15:0] sample_count, bad_sym_count;

  int checks = 0, errors = 0;
  bit ack_en = 1;
  int ack_max = 0;
  iss_t iss_q[$], exp_q[$];
  logic fin_q[$];
  int done_n = 0, d0 = 0;
  logic [15:0] b0, c0;
  vec_t vt[6];

  always #5 clk = ~clk;

  hdc_seq_ctrl dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .sym_last(sym_last), .sym_label(sym_label), .mode(mode), .dp_letter(dp_letter),
    .dp_position(dp_position), .dp_label(dp_label), .dp_t_signal(dp_t_signal),
    .dp_f_signal(dp_f_signal), .dp_mode(dp_mode), .dp_ack(dp_ack), .sample_done(sample_done),
    .sample_count(sample_count), .bad_sym_count(bad_sym_count), .err_overflow(err_overflow),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [4:0] d, input logic l, input logic [4:0] lab, input logic m);
    int n = 0;
    @(negedge clk);
    sym_data = d; sym_last = l; sym_label = lab; mode = m; sym_valid = 1;
    while (!sym_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_wait_ready", 0, 1);
    @(posedge clk);
    #1 sym_valid = 0;
  endtask

  task automatic start_sample();
    iss_q.delete(); fin_q.delete(); exp_q.delete();
    d0 = done_n; b0 = bad_sym_count; c0 = sample_count;
  endtask

  task automatic compare_sample(input string nm, input int efin, input logic emode,
                                input int ebad, input logic eovf);
    repeat (20) @(negedge clk);
    chk({nm, " issue_count"}, iss_q.size(), exp_q.size());
    for (int i = 0; i < iss_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s issue%0d", nm, i), iss_q[i], exp_q[i]);
    chk({nm, " finalize_count"}, fin_q.size(), efin);
    if (fin_q.size() > 0) chk({nm, " dp_mode"}, fin_q[0], emode);
    chk({nm, " done_pulses"}, done_n - d0, efin);
    chk({nm, " sample_count"}, 16'(sample_count - c0), efin);
    chk({nm, " bad_sym"}, 16'(bad_sym_count - b0), ebad);
    chk({nm, " err_overflow"}, err_overflow, eovf);
  endtask

  task automatic clear_errs();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  task automatic set_vec(input int i, input int n, input int s0, input int s1, input int s2,
                         input int lab, input int md, input int en, input int e0, input int e1,
                         input int e2, input int efin, input int ebad);
    vt[i].n = n; vt[i].syms = {5'(s2), 5'(s1), 5'(s0)}; vt[i].lab = 5'(lab); vt[i].md = 1'(md);
    vt[i].en = en; vt[i].elet = {5'(e2), 5'(e1), 5'(e0)}; vt[i].efin = efin; vt[i].ebad = ebad;
  endtask

  // datapath responder: one-cycle dp_ack after each strobe, optionally delayed
  initial forever begin
    @(negedge clk);
    if (ack_en && (dp_t_signal || dp_f_signal)) begin
      automatic int dly = $urandom_range(0, ack_max);
      @(posedge clk);
      repeat (dly) @(posedge clk);
      #1 dp_ack = 1;
      @(posedge clk);
      #1 dp_ack = 0;
    end
  end

  // monitor of issued symbols, finalizes and done pulses
  initial forever begin
    @(negedge clk);
    if (dp_t_signal) iss_q.push_back({dp_letter, dp_position, dp_label});
    if (dp_f_signal) fin_q.push_back(dp_mode);
    if (sample_done) done_n++;
  end

  initial begin
    set_vec(0, 3, 3, 1, 4, 2, 0, 3, 3, 1, 4, 1, 0);
    set_vec(1, 3, 7, 10, 5, 1, 1, 2, 7, 5, 0, 1, 1);
    set_vec(2, 1, 12, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1);
    set_vec(3, 2, 9, 0, 0, 31, 1, 2, 9, 0, 0, 1, 0);
    set_vec(4, 3, 5, 9, 31, 6, 0, 2, 5, 9, 0, 1, 1);
    set_vec(5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);

    #3 rst = 0;
    #1;
    chk("reset_dp", {dp_t_signal, dp_f_signal, sample_done, dp_letter, dp_position, dp_label, dp_mode}, 0);
    chk("reset_cnt", {sample_count, bad_sym_count, err_overflow, err_timeout}, 0);
    chk("reset_ready", sym_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1;

    for (int v = 0; v < 6; v++) begin
      start_sample();
      for (int i = 0; i < vt[v].en; i++) exp_q.push_back({vt[v].elet[i], 5'(i), vt[v].lab});
      for (int i = 0; i < vt[v].n; i++) send(vt[v].syms[i], i == vt[v].n - 1, vt[v].lab, vt[v].md);
      compare_sample($sformatf("vec%0d", v), vt[v].efin, vt[v].md, vt[v].ebad, 0);
      if (v == 0) chk("vec0 total_samples", sample_count, 1);
    end

    start_sample();
    for (int i = 0; i < ML; i++) exp_q.push_back({5'(i % 10), 5'(i), 5'd7});
    for (int i = 0; i < ML + 3; i++) send(5'(i % 10), i == ML + 2, 7, 1);
    compare_sample("overflow", 1, 1, 0, 1);
    start_sample();
    exp_q.push_back({5'd2, 5'd0, 5'd7});
    send(2, 1, 7, 0);
    compare_sample("after_overflow", 1, 0, 0, 1);
    clear_errs();
    @(negedge clk);
    chk("overflow_cleared", err_overflow, 0);

    start_sample();
    ack_en = 0;
    send(4, 0, 3, 0);
    repeat (60) @(negedge clk);
    chk("timeout_early", {err_timeout, sym_ready}, 2'b00);
    repeat (10) @(negedge clk);
    chk("timeout_set", {err_timeout, sym_ready}, 2'b11);
    chk("timeout_no_done", 16'(sample_count - c0), 0);
    chk("timeout_no_fin", fin_q.size(), 0);
    clear_errs();
    @(negedge clk);
    chk("timeout_cleared", err_timeout, 0);
    err_clr = 1;
    send(4, 0, 3, 0);
    for (int n = 0; n < 200 && !sym_ready; n++) @(negedge clk);
    chk("clr_vs_set", err_timeout, 1);
    err_clr = 0;
    @(negedge clk);
    chk("clr_vs_set_hold", err_timeout, 1);
    clear_errs();
    ack_en = 1;
    start_sample();
    exp_q.push_back({5'd6, 5'd0, 5'd3});
    send(6, 1, 3, 1);
    compare_sample("after_timeout", 1, 1, 0, 0);

    send(1, 0, 5, 0);
    repeat (4) @(negedge clk);
    ack_en = 0;
    send(2, 0, 5, 0);
    repeat (3) @(negedge clk);
    fin_q.delete();
    #2 rst = 0;
    #1;
    chk("midreset_dp", {dp_t_signal, dp_f_signal, sample_done, dp_letter, dp_position, dp_label, dp_mode}, 0);
    chk("midreset_cnt", {sample_count, bad_sym_count, err_overflow, err_timeout}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    ack_en = 1;
    repeat (5) @(negedge clk);
    chk("midreset_no_fin", fin_q.size(), 0);
    start_sample();
    exp_q.push_back({5'd8, 5'd0, 5'd9});
    send(8, 1, 9, 0);
    compare_sample("after_reset", 1, 0, 0, 0);

    ack_max = 3;
    for (int s = 0; s < 40; s++) begin
      automatic int n = $urandom_range(1, 26);
      automatic logic [4:0] lab = 5'($urandom_range(0, 31));
      automatic logic md = 1'($urandom_range(0, 1));
      automatic int pos = 0, bad = 0;
      automatic bit drain = 0, ovf = 0, fin = 0;
      start_sample();
      for (int k = 0; k < n; k++) begin
        automatic logic [4:0] d = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
        automatic bit l = (k == n - 1);
        send(d, l, lab, md);
        if (!drain && d > 9) begin
          bad++;
          if (l && pos > 0) fin = 1;
        end else if (!drain) begin
          exp_q.push_back({d, 5'(pos), lab});
          pos++;
          if (l) fin = 1;
          else if (pos == ML) begin ovf = 1; fin = 1; drain = 1; end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      compare_sample($sformatf("rand%0d", s), int'(fin), md, bad, ovf);
      clear_errs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
